// File: rtl/vc_alloc_if.sv
// Handshake bundle between the input-VC requesters and one output-port VC allocator.
interface vc_alloc_if #(
   parameter int REQ_NUM = 10,
   parameter int VC_NUM  = 2,
   parameter int VC_SIZE = $clog2(VC_NUM)
);
   logic [REQ_NUM-1:0] req_i;
   logic [VC_NUM-1:0]  release_i;
   logic [REQ_NUM-1:0] grant_o;
   logic [VC_SIZE-1:0] grant_vc_o;
   logic [VC_NUM-1:0]  vc_busy_o;
   logic               error_o;

   modport master (
      output req_i, release_i,
      input  grant_o, grant_vc_o, vc_busy_o, error_o
   );

   modport slave (
      input  req_i, release_i,
      output grant_o, grant_vc_o, vc_busy_o, error_o
   );
endinterface

// File: rtl/vc_allocator_out.sv
// Output-port VC allocator: round-robin over requesting input VCs, lowest free
// downstream VC, registered grant with the just-granted requester masked for a cycle.
module vc_allocator_out #(
   parameter int REQ_NUM = 10,
   parameter int VC_NUM  = 2,
   parameter int VC_SIZE = $clog2(VC_NUM)
) (
   input logic       clk,
   input logic       rst,
   vc_alloc_if.slave bus
);
   localparam int IDX_W = $clog2(REQ_NUM);

   logic [REQ_NUM-1:0] r_grant;
   logic [VC_SIZE-1:0] r_grant_vc;
   logic [VC_NUM-1:0]  r_busy;
   logic               r_err;
   logic [IDX_W-1:0]   r_last;

   logic [REQ_NUM-1:0] w_masked;
   logic [REQ_NUM-1:0] w_grant_vec;
   logic [VC_NUM-1:0]  w_vc_vec;
   logic [VC_SIZE-1:0] w_vc;
   logic [IDX_W-1:0]   w_sel;
   logic               w_vc_found;
   logic               w_req_found;
   logic               w_grant_en;
   logic               w_err;
   int                 w_k;

   always_comb begin
      // The previous grant is still visible on r_grant; its owner keeps req high while consuming it.
      w_masked    = bus.req_i & ~r_grant;
      w_vc_found  = 1'b0;
      w_vc        = '0;
      w_req_found = 1'b0;
      w_sel       = '0;
      w_k         = 0;
      w_grant_vec = '0;
      w_vc_vec    = '0;

      for (int v = VC_NUM - 1; v >= 0; v--) begin
         if (!r_busy[VC_SIZE'(v)]) begin
            w_vc_found = 1'b1;
            w_vc       = VC_SIZE'(v);
         end
      end

      for (int i = 1; i <= REQ_NUM; i++) begin
         w_k = int'(r_last) + i;
         if (w_k >= REQ_NUM) w_k = w_k - REQ_NUM;
         if (!w_req_found && w_masked[IDX_W'(w_k)]) begin
            w_req_found = 1'b1;
            w_sel       = IDX_W'(w_k);
         end
      end

      w_grant_en = w_req_found && w_vc_found;
      if (w_grant_en) begin
         w_grant_vec[w_sel] = 1'b1;
         w_vc_vec[w_vc]     = 1'b1;
      end

      w_err = |(bus.release_i & ~r_busy);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant    <= '0;
         r_grant_vc <= '0;
         r_busy     <= '0;
         r_err      <= 1'b0;
         r_last     <= IDX_W'(REQ_NUM - 1);
      end else begin
         r_grant    <= w_grant_vec;
         r_grant_vc <= w_grant_en ? w_vc : '0;
         // Releases of already-free VCs clear nothing, so the map is naturally unchanged by them.
         r_busy     <= (r_busy & ~bus.release_i) | w_vc_vec;
         r_err      <= w_err;
         if (w_grant_en) r_last <= w_sel;
      end
   end

   assign bus.grant_o    = r_grant;
   assign bus.grant_vc_o = r_grant_vc;
   assign bus.vc_busy_o  = r_busy;
   assign bus.error_o    = r_err;
endmodule

// File: tb/tb_vc_allocator_out.sv
// Bench for vc_allocator_out: a behavioural model predicts each cycle's outputs into
// a scoreboard queue; entries are popped and compared just after the clock edge.
module tb_vc_allocator_out;
   localparam int RN = 10;
   localparam int VN = 2;

   typedef struct packed {
      logic [RN-1:0] g;
      logic [0:0]    vc;
      logic [VN-1:0] b;
      logic          e;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];

   logic [RN-1:0] m_grant;
   logic [0:0]    m_vc;
   logic [VN-1:0] m_busy;
   logic          m_err;
   int            m_last;

   vc_alloc_if #(.REQ_NUM(RN), .VC_NUM(VN)) bus ();

   vc_allocator_out #(.REQ_NUM(RN), .VC_NUM(VN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Drive one cycle, predict its result, then compare after the edge.
   task automatic step(input logic r, input logic [RN-1:0] rq, input logic [VN-1:0] rl);
      exp_t          e;
      logic [RN-1:0] masked;
      logic [RN-1:0] ng;
      logic [VN-1:0] nv;
      int            free_v;
      int            idx;
      rst           = r;
      bus.req_i     = rq;
      bus.release_i = rl;
      if (r) begin
         m_grant = '0; m_vc = '0; m_busy = '0; m_err = 1'b0; m_last = RN - 1;
      end else begin
         masked = rq & ~m_grant;
         ng = '0; nv = '0;
         free_v = -1;
         for (int v = 0; v < VN; v++)
            if (free_v < 0 && !m_busy[v]) free_v = v;
         if (masked != 0 && free_v >= 0) begin
            for (int off = 1; off <= RN; off++) begin
               idx = (m_last + off) % RN;
               if (ng == 0 && masked[idx]) ng[idx] = 1'b1;
            end
            for (int j = 0; j < RN; j++) if (ng[j]) m_last = j;
            nv[free_v] = 1'b1;
            m_vc = 1'(free_v);
         end else begin
            m_vc = '0;
         end
         m_err   = |(rl & ~m_busy);
         m_busy  = (m_busy & ~rl) | nv;
         m_grant = ng;
      end
      e.g = m_grant; e.vc = m_vc; e.b = m_busy; e.e = m_err;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk("grant", 32'(bus.grant_o), 32'(e.g));
      chk("grant_vc", 32'(bus.grant_vc_o), 32'(e.vc));
      chk("busy", 32'(bus.vc_busy_o), 32'(e.b));
      chk("error", 32'(bus.error_o), 32'(e.e));
   endtask

   initial begin
      bus.req_i = '0;
      bus.release_i = '0;
      m_grant = '0; m_vc = '0; m_busy = '0; m_err = 1'b0; m_last = RN - 1;

      step(1, '0, '0);
      step(1, '0, '0);
      chk("rst_grant", 32'(bus.grant_o), 0);
      chk("rst_busy", 32'(bus.vc_busy_o), 0);

      // single request right after reset
      step(0, 10'h001, '0);
      chk("first_grant", 32'(bus.grant_o), 32'h001);
      chk("first_busy", 32'(bus.vc_busy_o), 32'h1);
      step(0, '0, 2'b01);

      // two held requesters, second one is masked then served
      step(0, 10'h006, '0);
      chk("pair_g1", 32'(bus.grant_o), 32'h002);
      step(0, 10'h006, '0);
      chk("pair_g2", 32'(bus.grant_o), 32'h004);
      chk("pair_vc2", 32'(bus.grant_vc_o), 32'h1);
      step(0, 10'h006, '0);
      chk("pair_none", 32'(bus.grant_o), 0);
      chk("pair_full", 32'(bus.vc_busy_o), 32'h3);

      // release while full: grant lands two cycles later
      step(0, 10'h020, 2'b10);
      chk("rel_busy", 32'(bus.vc_busy_o), 32'h1);
      chk("rel_nogrant", 32'(bus.grant_o), 0);
      step(0, 10'h020, '0);
      chk("rel_grant", 32'(bus.grant_o), 32'h020);
      chk("rel_vc", 32'(bus.grant_vc_o), 32'h1);
      step(0, '0, '0);
      step(0, '0, 2'b11);

      // round-robin wrap from requester 9 back to 0
      step(0, 10'h200, '0);
      chk("rr_g9", 32'(bus.grant_o), 32'h200);
      step(0, '0, 2'b01);
      step(0, 10'h201, '0);
      chk("rr_wrap0", 32'(bus.grant_o), 32'h001);
      step(0, 10'h201, '0);
      chk("rr_then9", 32'(bus.grant_o), 32'h200);
      step(0, '0, 2'b11);

      // spurious release
      step(0, '0, 2'b01);
      chk("err_pulse", 32'(bus.error_o), 1);
      chk("err_busy", 32'(bus.vc_busy_o), 0);
      step(0, '0, '0);
      chk("err_clear", 32'(bus.error_o), 0);

      // reset right after a decision discards the pending grant
      step(0, 10'h001, '0);
      step(1, '0, '0);
      chk("midrst_grant", 32'(bus.grant_o), 0);
      chk("midrst_busy", 32'(bus.vc_busy_o), 0);

      // randomised traffic, releases concurrent with grants
      for (int n = 0; n < 400; n++) begin
         logic          r;
         logic [RN-1:0] rq;
         logic [VN-1:0] rl;
         r  = ($urandom_range(0, 49) == 0);
         rq = RN'($urandom_range(0, 1023));
         if ($urandom_range(0, 1) == 0) rq = rq & RN'($urandom_range(0, 1023));
         rl = ($urandom_range(0, 2) == 0) ? VN'($urandom_range(0, 3)) : '0;
         step(r, rq, rl);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/vc_allocator_out.md
VC_ALLOCATOR_OUT -- requirements
Module: vc_allocator_out

Interface
REQ-001 Parameter REQ_NUM, default 10, number of upstream input VCs (5 ports x 2 VCs) competing for this output port.
REQ-002 Parameter VC_NUM, default 2, number of downstream VCs owned by this output port.
REQ-003 Parameter VC_SIZE, default $clog2(VC_NUM), width of a downstream VC identifier.
REQ-004 The block SHALL have exactly one clock, clk, and one reset, rst.
REQ-005 rst is synchronous and active-high.
REQ-006 Port list:
  clk  input  1  clock, rising edge.
  rst  input  1  synchronous active-high reset.
  req_i  input  REQ_NUM  bit i high means input VC i is in VA state and requests a downstream VC on this port.
  release_i  input  VC_NUM  one-cycle pulse per VC; the downstream VC is freed (tail flit departed).
  grant_o  output  REQ_NUM  registered one-hot grant, high for one cycle.
  grant_vc_o  output  VC_SIZE  downstream VC assigned with grant_o; valid only when grant_o is nonzero.
  vc_busy_o  output  VC_NUM  registered ownership map; bit v high means VC v is allocated.
  error_o  output  1  registered one-cycle protocol-error pulse.

Function
REQ-007 Each cycle, the allocation decision SHALL use the registered vc_busy_o state and the current req_i, masked as in REQ-012.
REQ-008 At most one grant is issued per cycle.
REQ-009 A grant SHALL occur in cycle t only when the masked req_i is nonzero and at least one VC is free (vc_busy_o bit low).
REQ-010 Requester selection is round-robin:
  - the search starts at (last_granted + 1) mod REQ_NUM and wraps around;
  - last_granted resets to REQ_NUM-1, so index 0 has first priority after reset.
REQ-011 The allocated VC SHALL be the lowest-index free VC.
REQ-012 Grant latency and masking:
  - a decision in cycle t appears on grant_o and grant_vc_o in cycle t+1;
  - the requester granted in cycle t SHALL be masked out of arbitration in cycle t+1, because its req_i is still high while it consumes the grant.
REQ-013 last_granted SHALL update only on a grant; with no grant it holds.
REQ-014 Busy-map update: vc_busy_next = (vc_busy_o & ~release_i) | onehot(allocated VC).
REQ-015 A VC released in cycle t SHALL NOT be allocatable before cycle t+1.
  - If all VCs are busy and a release arrives in cycle t, the earliest grant of that VC is decided in t+1 and visible in t+2.
REQ-016 A release_i bit asserted for a VC whose vc_busy_o bit is low SHALL set error_o in the next cycle; the busy map is unchanged by that bit.
REQ-017 Any bit of release_i may assert concurrently with a grant. Each releasing bit is handled per REQ-014 and REQ-016, independently of the grant.
REQ-018 With all VCs busy, requests SHALL wait indefinitely.
  - grant_o stays zero;
  - the round-robin pointer holds.
REQ-019 When grant_o is zero, grant_vc_o SHALL be 0.
REQ-020 error_o SHALL be low in every cycle without a protocol error.

Reset
REQ-021 While rst is high at a clock edge:
  - grant_o = 0, grant_vc_o = 0, vc_busy_o = 0, error_o = 0;
  - last_granted = REQ_NUM-1;
  - the grant mask is cleared.
REQ-022 Reset asserted mid-operation SHALL discard all allocations and the pending grant.
REQ-023 No grant is issued in the cycle following reset deassertion unless req_i was high in the first cycle with rst low.

Verification
REQ-024 Reset, then req_i=0b0000000001 for 1 cycle -> grant_o=0b0000000001 and grant_vc_o=0 next cycle; vc_busy_o=0b01.
REQ-025 req_i=0b0000000110 held high, VC_NUM=2, all free:
  - first grant to requester 1 with VC 0;
  - requester 1 masked in the following cycle;
  - then requester 2 granted with VC 1;
  - then no grants; vc_busy_o=0b11.
REQ-026 Both VCs busy, req_i bit 5 high, release_i=0b10 in cycle t:
  - vc_busy_o=0b01 at t+1;
  - grant_o bit 5 with grant_vc_o=1 at t+2.
REQ-027 Round-robin fairness: after granting requester 9 and freeing all VCs, req_i=0b1000000001 -> next grant goes to requester 0 (wrap), then to requester 9.
REQ-028 release_i=0b01 while vc_busy_o=0b00 -> error_o=1 for exactly one cycle; vc_busy_o stays 0b00.
REQ-029 rst asserted in the cycle after a decision -> grant_o=0 and vc_busy_o=0 after the reset edge; the pending grant is never seen.
